// File: rtl/mem_arb_pkg.sv
// Shared state encoding and master indices for the two-master RAM arbiter.
// No logic: types and constants only.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_LDR = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Master-side request/grant/read-return signals plus the RAM-side port of the arbiter.
// master = masters + RAM model view, slave = arbiter view.
interface mem_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 10
);
  logic              m0_req,    m1_req;
  logic              m0_lock,   m1_lock;
  logic              m0_we,     m1_we;
  logic [ADDR_W-1:0] m0_addr,   m1_addr;
  logic [XLEN-1:0]   m0_wdata,  m1_wdata;
  logic              m0_gnt,    m1_gnt;
  logic              m0_rvalid, m1_rvalid;
  logic [XLEN-1:0]   m0_rdata,  m1_rdata;
  logic              s_cs;
  logic              s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [XLEN-1:0]   s_wdata;
  logic [XLEN-1:0]   s_rdata;

  modport master (
    output m0_req, m1_req, m0_lock, m1_lock, m0_we, m1_we,
           m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           s_cs, s_we, s_addr, s_wdata
  );

  modport slave (
    input  m0_req, m1_req, m0_lock, m1_lock, m0_we, m1_we,
           m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           s_cs, s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/arb_prio2.sv
// Combinational 2-way pick, one-hot result; MEM_ARB_ROUND_ROBIN_EN selects round-robin
// tie-break against `last`, otherwise master 0 always wins ties. Zero latency.
module arb_prio2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    win = req;
    if (req == 2'b11) begin
      win = (last == M_LDR) ? 2'b01 : 2'b10;
    end
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    win = 2'b00;
    if (req[M_CPU]) begin
      win[M_CPU] = 1'b1;
    end else if (req[M_LDR]) begin
      win[M_LDR] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter onto a 1-cycle-read RAM: 0-cycle grant, rvalid 1 cycle after a read,
// locked bursts capped at MAX_BURST when the other master waits; MEM_ARB_ROUND_ROBIN_EN = RR ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 10,
  parameter int MAX_BURST = 8
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam int              CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_owner_q, rd_owner_d;
  logic             yield_q, yield_d;
  logic             yield_to_q, yield_to_d;
  logic [1:0]       req, pick, gnt;
  logic             own, own_lock;

  assign req = {bus.m1_req, bus.m0_req};

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  assign last_d = (|gnt) ? gnt[M_LDR] : last_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) last_q <= M_LDR;
    else        last_q <= last_d;
  end

  arb_prio2 u_prio (.req(req), .last(last_q), .win(pick));
`else
  arb_prio2 u_prio (.req(req), .last(M_LDR), .win(pick));
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    yield_d    = 1'b0;
    yield_to_d = yield_to_q;
    gnt        = 2'b00;
    own        = (state_q == ARB_OWN1) ? M_LDR : M_CPU;
    own_lock   = own ? bus.m1_lock : bus.m0_lock;
    cnt_inc    = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    unique case (state_q)
      ARB_IDLE: begin
        cnt_d = '0;
        // A capped burst hands the very next slot to the master it held off.
        if (yield_q && req[yield_to_q]) gnt = yield_to_q ? 2'b10 : 2'b01;
        else                            gnt = pick;
        if (gnt[M_LDR] && bus.m1_lock) begin
          state_d = ARB_OWN1;
          cnt_d   = CNT_W'(1);
        end else if (gnt[M_CPU] && bus.m0_lock) begin
          state_d = ARB_OWN0;
          cnt_d   = CNT_W'(1);
        end
      end
      ARB_OWN0, ARB_OWN1: begin
        if (req[own]) begin
          gnt      = own ? 2'b10 : 2'b01;
          cnt_d    = cnt_inc;
          if (!own_lock) begin
            state_d = ARB_IDLE;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_MAX && req[~own]) begin
            state_d    = ARB_IDLE;
            cnt_d      = '0;
            yield_d    = 1'b1;
            yield_to_d = ~own;
          end
        end else begin
          state_d = ARB_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    // Nothing reaches the RAM while reset is held, even if masters keep requesting.
    if (!reset) gnt = 2'b00;
  end

  assign bus.m0_gnt  = gnt[M_CPU];
  assign bus.m1_gnt  = gnt[M_LDR];
  assign bus.s_cs    = |gnt;
  assign bus.s_we    = bus.s_cs & (gnt[M_LDR] ? bus.m1_we : bus.m0_we);
  assign bus.s_addr  = gnt[M_LDR] ? bus.m1_addr  : bus.m0_addr;
  assign bus.s_wdata = gnt[M_LDR] ? bus.m1_wdata : bus.m0_wdata;

  assign rd_pend_d  = bus.s_cs & ~bus.s_we;
  assign rd_owner_d = bus.s_cs ? gnt[M_LDR] : rd_owner_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ARB_IDLE;
      cnt_q      <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= M_CPU;
      yield_q    <= 1'b0;
      yield_to_q <= M_CPU;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      yield_q    <= yield_d;
      yield_to_q <= yield_to_d;
    end
  end

  assign bus.m0_rvalid = rd_pend_q & (rd_owner_q == M_CPU);
  assign bus.m1_rvalid = rd_pend_q & (rd_owner_q == M_LDR);
  assign bus.m0_rdata  = bus.m0_rvalid ? bus.s_rdata : '0;
  assign bus.m1_rdata  = bus.m1_rvalid ? bus.s_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle-read RAM.
// Tie-order expectations follow MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_arbiter_if #(.XLEN(32), .ADDR_W(10)) bus ();

  mem_arbiter #(.XLEN(32), .ADDR_W(10), .MAX_BURST(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:1023];
  logic [31:0] ram_q = 32'h0;
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = 10'h0;
  logic [31:0] pre_dat = 32'h0;
  int          wr_cnt = 0;

  always @(posedge clock) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_dat;
    end else if (bus.s_cs) begin
      if (bus.s_we) begin
        mem[bus.s_addr] <= bus.s_wdata;
        wr_cnt <= wr_cnt + 1;
      end else begin
        ram_q <= mem[bus.s_addr];
      end
    end
  end
  assign bus.s_rdata = ram_q;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_dat = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic set_m0(input logic r, input logic l, input logic w, input logic [9:0] a, input logic [31:0] d);
    bus.m0_req = r; bus.m0_lock = l; bus.m0_we = w; bus.m0_addr = a; bus.m0_wdata = d;
  endtask

  task automatic set_m1(input logic r, input logic l, input logic w, input logic [9:0] a, input logic [31:0] d);
    bus.m1_req = r; bus.m1_lock = l; bus.m1_we = w; bus.m1_addr = a; bus.m1_wdata = d;
  endtask

  logic [3:0] tie_exp;
  logic       prev_win;
  int         b;
  int         wr_snap;

  initial begin
    set_m0(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
    set_m1(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
    preload(10'h010, 32'hDEADBEEF);
    preload(10'h020, 32'h12345678);
    preload(10'h021, 32'hCAFEF00D);
    preload(10'h302, 32'h0BADC0DE);

    // Reset held with both masters requesting: nothing may be granted.
    set_m0(1'b1, 1'b0, 1'b1, 10'h3FF, 32'hFFFF_FFFF);
    set_m1(1'b1, 1'b0, 1'b1, 10'h3FE, 32'hFFFF_FFFF);
    #1;
    chk("rst_m0_gnt",    32'(bus.m0_gnt),    32'd0);
    chk("rst_m1_gnt",    32'(bus.m1_gnt),    32'd0);
    chk("rst_s_cs",      32'(bus.s_cs),      32'd0);
    chk("rst_s_we",      32'(bus.s_we),      32'd0);
    chk("rst_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
    chk("rst_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
    chk("rst_m0_rdata",  bus.m0_rdata,       32'd0);
    chk("rst_m1_rdata",  bus.m1_rdata,       32'd0);
    tick();

    // Tie straight out of reset, held for four cycles.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    tie_exp = 4'b1010;
`else
    tie_exp = 4'b0000;
`endif
    reset = 1'b1;
    set_m0(1'b1, 1'b0, 1'b0, 10'h010, 32'h0);
    set_m1(1'b1, 1'b0, 1'b0, 10'h010, 32'h0);
    prev_win = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("tie%0d_m0_gnt", c), 32'(bus.m0_gnt), 32'(!tie_exp[c]));
      chk($sformatf("tie%0d_m1_gnt", c), 32'(bus.m1_gnt), 32'(tie_exp[c]));
      if (c > 0) begin
        chk($sformatf("tie%0d_m0_rvalid", c), 32'(bus.m0_rvalid), 32'(!prev_win));
        chk($sformatf("tie%0d_m1_rvalid", c), 32'(bus.m1_rvalid), 32'(prev_win));
      end
      prev_win = tie_exp[c];
      tick();
    end
    set_m0(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
    set_m1(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
    tick();

    // Single read by m0.
    set_m0(1'b1, 1'b0, 1'b0, 10'h010, 32'h0);
    #1;
    chk("rd_m0_gnt",  32'(bus.m0_gnt), 32'd1);
    chk("rd_m1_gnt",  32'(bus.m1_gnt), 32'd0);
    chk("rd_s_cs",    32'(bus.s_cs),   32'd1);
    chk("rd_s_we",    32'(bus.s_we),   32'd0);
    chk("rd_s_addr",  32'(bus.s_addr), 32'h010);
    tick();
    set_m0(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
    #1;
    chk("rd_m0_rvalid", 32'(bus.m0_rvalid), 32'd1);
    chk("rd_m0_rdata",  bus.m0_rdata,       32'hDEADBEEF);
    chk("rd_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
    chk("rd_m1_rdata",  bus.m1_rdata,       32'd0);
    chk("rd_s_cs_idle", 32'(bus.s_cs),      32'd0);
    tick();
    chk("rd_m0_rvalid_drop", 32'(bus.m0_rvalid), 32'd0);

    // Locked m1 write burst of 12 beats, m0 reading from cycle 2 until served.
    b = 0;
    for (int c = 1; c <= 13; c++) begin
      set_m1(1'b1, (b != 11), 1'b1, 10'h100 + 10'(b), 32'hA0 + 32'(b));
      set_m0((c >= 2 && c <= 9), 1'b0, 1'b0, 10'h010, 32'h0);
      #1;
      chk($sformatf("burst%0d_m1_gnt", c), 32'(bus.m1_gnt), 32'(c != 9));
      chk($sformatf("burst%0d_m0_gnt", c), 32'(bus.m0_gnt), 32'(c == 9));
      if (c == 10) begin
        chk("burst_m0_rvalid", 32'(bus.m0_rvalid), 32'd1);
        chk("burst_m0_rdata",  bus.m0_rdata,       32'hDEADBEEF);
        chk("burst_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
      end
      if (c != 9) b++;
      tick();
    end
    set_m1(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
    set_m0(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
    tick();
    chk("burst_mem_100", mem[10'h100], 32'hA0);
    chk("burst_mem_107", mem[10'h107], 32'hA7);
    chk("burst_mem_108", mem[10'h108], 32'hA8);
    chk("burst_mem_10B", mem[10'h10B], 32'hAB);

    // m0 locks three beats, drops lock on the third; m1 waits with a read.
    for (int c = 1; c <= 4; c++) begin
      set_m0((c <= 3), (c != 3), 1'b1, 10'h200 + 10'(c), 32'h200 + 32'(c));
      set_m1(1'b1, 1'b0, 1'b0, 10'h010, 32'h0);
      #1;
      chk($sformatf("lock%0d_m0_gnt", c), 32'(bus.m0_gnt), 32'(c <= 3));
      chk($sformatf("lock%0d_m1_gnt", c), 32'(bus.m1_gnt), 32'(c == 4));
      tick();
    end
    set_m0(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
    set_m1(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
    #1;
    chk("lock_m1_rvalid", 32'(bus.m1_rvalid), 32'd1);
    chk("lock_m1_rdata",  bus.m1_rdata,       32'hDEADBEEF);
    chk("lock_m0_rdata",  bus.m0_rdata,       32'd0);
    tick();

    // Back-to-back reads from different masters.
    set_m0(1'b1, 1'b0, 1'b0, 10'h020, 32'h0);
    #1;
    chk("b2b_m0_gnt", 32'(bus.m0_gnt), 32'd1);
    tick();
    set_m0(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
    set_m1(1'b1, 1'b0, 1'b0, 10'h021, 32'h0);
    #1;
    chk("b2b_m1_gnt",    32'(bus.m1_gnt),    32'd1);
    chk("b2b_m0_rvalid", 32'(bus.m0_rvalid), 32'd1);
    chk("b2b_m0_rdata",  bus.m0_rdata,       32'h12345678);
    tick();
    set_m1(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
    #1;
    chk("b2b_m1_rvalid", 32'(bus.m1_rvalid), 32'd1);
    chk("b2b_m1_rdata",  bus.m1_rdata,       32'hCAFEF00D);
    chk("b2b_m0_rvalid_off", 32'(bus.m0_rvalid), 32'd0);
    chk("b2b_m0_rdata_off",  bus.m0_rdata,       32'd0);
    tick();

    // Reset during beat 3 of an m1 burst whose beat 2 was a read.
    set_m1(1'b1, 1'b1, 1'b1, 10'h300, 32'h55);
    #1;
    chk("rstb_beat1_gnt", 32'(bus.m1_gnt), 32'd1);
    tick();
    set_m1(1'b1, 1'b1, 1'b0, 10'h010, 32'h0);
    #1;
    chk("rstb_beat2_gnt", 32'(bus.m1_gnt), 32'd1);
    tick();
    wr_snap = wr_cnt;
    set_m1(1'b1, 1'b1, 1'b1, 10'h302, 32'h57);
    reset = 1'b0;
    #1;
    chk("rstb_m1_gnt",    32'(bus.m1_gnt),    32'd0);
    chk("rstb_s_cs",      32'(bus.s_cs),      32'd0);
    chk("rstb_s_we",      32'(bus.s_we),      32'd0);
    chk("rstb_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
    chk("rstb_m1_rdata",  bus.m1_rdata,       32'd0);
    tick();
    chk("rstb_no_write",  32'(wr_cnt - wr_snap), 32'd0);
    chk("rstb_mem_302",   mem[10'h302],          32'h0BADC0DE);
    chk("rstb_mem_300",   mem[10'h300],          32'h55);
    set_m1(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
    set_m0(1'b1, 1'b0, 1'b0, 10'h020, 32'h0);
    reset = 1'b1;
    #1;
    chk("rstb_post_m0_gnt", 32'(bus.m0_gnt), 32'd1);
    chk("rstb_post_m1_gnt", 32'(bus.m1_gnt), 32'd0);
    chk("rstb_post_s_we",   32'(bus.s_we),   32'd0);
    chk("rstb_post_s_addr", 32'(bus.s_addr), 32'h020);
    tick();
    set_m0(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
    #1;
    chk("rstb_post_rvalid", 32'(bus.m0_rvalid), 32'd1);
    chk("rstb_post_rdata",  bus.m0_rdata,       32'h12345678);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
